// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/forward sequencer for the 5-stage core, with memory-wait FSM, timeout fault and stall counter
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1E,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2E,
  input  logic [REG_ADDR_WIDTH-1:0] RdE,
  input  logic [REG_ADDR_WIDTH-1:0] RdM,
  input  logic [REG_ADDR_WIDTH-1:0] RdW,
  input  logic [1:0]                ResultSrcE,
  input  logic                      RegWriteM,
  input  logic                      RegWriteW,
  input  logic                      PCSrcE,
  input  logic                      MemReqM,
  input  logic                      MemReadyM,
  output logic                      StallF,
  output logic                      StallD,
  output logic                      StallE,
  output logic                      StallM,
  output logic                      FlushD,
  output logic                      FlushE,
  output logic                      FlushW,
  output logic [1:0]                ForwardAE,
  output logic [1:0]                ForwardBE,
  output logic                      Fault,
  output logic [CNT_WIDTH-1:0]      StallCount
);
  localparam int TW = $clog2(MEM_TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'(MEM_TIMEOUT - 1);
  typedef enum logic [1:0] {RUN = 2'b00, MEM_WAIT = 2'b01, FAULT = 2'b10} state_t;
  state_t state;
  logic [TW-1:0] timer;
  logic mem_stall, lw_stall;
  function automatic logic [1:0] fwd(input logic [REG_ADDR_WIDTH-1:0] rs);
    return (RegWriteM && RdM != '0 && RdM == rs) ? 2'b10 :
           (RegWriteW && RdW != '0 && RdW == rs) ? 2'b01 : 2'b00;
  endfunction
  assign mem_stall = (state == RUN && MemReqM && !MemReadyM) || (state == MEM_WAIT && !MemReadyM) || state == FAULT;
  assign lw_stall = ResultSrcE == 2'b01 && RdE != '0 && (RdE == Rs1D || RdE == Rs2D);
  // a resolved branch outranks a load-use stall, but a memory stall holds the branch in E
  assign StallF = !rst && (mem_stall || (!PCSrcE && lw_stall));
  assign StallD = StallF;
  assign StallE = !rst && mem_stall;
  assign StallM = StallE;
  assign FlushD = rst || (!mem_stall && PCSrcE);
  assign FlushE = rst || (!mem_stall && (PCSrcE || lw_stall));
  assign FlushW = rst || mem_stall;
  assign ForwardAE = rst ? 2'b00 : fwd(Rs1E);
  assign ForwardBE = rst ? 2'b00 : fwd(Rs2E);
  assign Fault = state == FAULT;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      timer <= '0;
      StallCount <= '0;
    end else begin
      if (state == RUN && MemReqM && !MemReadyM) begin
        state <= MEM_WAIT;
        timer <= '0;
      end else if (state == MEM_WAIT) begin
        if (MemReadyM) state <= RUN;
        else if (timer == TLAST) state <= FAULT;
        else timer <= timer + 1'b1;
      end
      if (StallF && StallCount != '1) StallCount <= StallCount + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and random checks against a streak-based reference model
module tb_pipeline_hazard_ctrl;
  localparam int MT = 4;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] ResultSrcE;
  logic RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, Fault;
  logic [1:0] ForwardAE, ForwardBE;
  logic [CW-1:0] StallCount;
  int n_tests = 0;
  int n_fail = 0;
  int streak = 0;
  int cnt = 0;
  bit faulted = 0;
  int cnt0;

  pipeline_hazard_ctrl #(.REG_ADDR_WIDTH(5), .MEM_TIMEOUT(MT), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .ForwardAE(ForwardAE),
    .ForwardBE(ForwardBE), .Fault(Fault), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  // called at a negedge with inputs applied; returns at the following negedge
  task automatic tick();
    bit ms, lw;
    logic [6:0] ctl;
    ms = faulted || (streak > 0 ? !MemReadyM : (MemReqM && !MemReadyM));
    lw = ResultSrcE == 2'b01 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    ctl = rst ? 7'b0000111 : ms ? 7'b1111001 : PCSrcE ? 7'b0000110 : lw ? 7'b1100010 : 7'b0;
    #1;
    check("ctl", {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}, ctl);
    check("fwd", {ForwardAE, ForwardBE}, rst ? 4'b0 : {fwd_ref(Rs1E), fwd_ref(Rs2E)});
    check("fault", Fault, faulted);
    check("cnt", StallCount, cnt);
    @(posedge clk);
    if (rst) begin
      streak = 0;
      faulted = 0;
      cnt = 0;
    end else begin
      if (ctl[6] && cnt < CMAX) cnt++;
      if (ms && !faulted) begin
        streak++;
        if (streak == MT + 1) faulted = 1;
      end else if (!ms) streak = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {ResultSrcE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM} = '0;
    rst = 1'b1;
    @(negedge clk);
    tick();
    rst = 1'b0;
    RdM = 5; RegWriteM = 1; Rs1E = 5; RdW = 5; RegWriteW = 1;
    tick();
    check("fwdA_m_prio", ForwardAE, 2'b10);
    RegWriteM = 0;
    tick();
    check("fwdA_w", ForwardAE, 2'b01);
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
    tick();
    check("lw_stall", {StallF, StallD, FlushE}, 3'b111);
    RdE = 0;
    tick();
    check("lw_rd0", {StallF, StallD, FlushE}, 3'b000);
    RdE = 7; PCSrcE = 1;
    tick();
    check("br_over_lw", {FlushD, FlushE, StallF}, 3'b110);
    ResultSrcE = 2'b00;
    cnt0 = int'(StallCount);
    MemReqM = 1; MemReadyM = 0;
    repeat (3) begin
      tick();
      check("wait_hold_br", {StallF, StallM, FlushW, FlushD}, 4'b1110);
    end
    MemReadyM = 1;
    #1 check("release", {StallF, FlushD, FlushE}, 3'b011);
    tick();
    check("cnt_plus3", StallCount, cnt0 + 3);
    PCSrcE = 0; MemReqM = 1; MemReadyM = 0;
    repeat (MT + 1) tick();
    check("fault_set", Fault, 1'b1);
    MemReqM = 0; MemReadyM = 1;
    repeat ((1 << CW) + 5) tick();
    check("cnt_sat", {StallF, StallCount}, {1'b1, 4'hF});
    rst = 1;
    tick();
    rst = 0;
    check("rst_clear", {Fault, StallCount}, 5'b0);
    repeat (3000) begin
      rst = $urandom_range(0, 40) == 0;
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE = 5'($urandom_range(0, 3)); RdM = 5'($urandom_range(0, 3)); RdW = 5'($urandom_range(0, 3));
      ResultSrcE = 2'($urandom_range(0, 3));
      RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      PCSrcE = $urandom_range(0, 4) == 0;
      MemReqM = $urandom_range(0, 2) == 0;
      MemReadyM = 1'($urandom);
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
